uart_frame_link: RTL

//  Framed, checksummed byte-protocol engine between the UART byte core and board I/O state.
//  RX: parses host frames and updates the switch and button registers.
//  TX: emits LED and 7-seg element state frames on change or on a periodic refresh.

---
 rtl/uart_link_pkg.sv | 33 +++
 rtl/uart_frame_tx.sv | 162 ++++++++++++++++
 rtl/uart_frame_link.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/uart_link_pkg.sv
// Shared constants and types for the framed UART link.
//   - SYNC / TYPE byte values for both directions
//   - rx_state_t / tx_state_t FSM encodings
//   - nbytes(w): number of payload bytes needed to carry a w-bit value
package uart_link_pkg;

  localparam logic [7:0] RX_SYNC      = 8'hA5;
  localparam logic [7:0] RX_TYPE_SW   = 8'h01;
  localparam logic [7:0] RX_TYPE_BTN  = 8'h02;
  localparam logic [7:0] TX_SYNC      = 8'h5A;
  localparam logic [7:0] TX_TYPE_LED  = 8'h81;
  localparam logic [7:0] TX_TYPE_ELEM = 8'h82;

  typedef enum logic [1:0] {
    R_IDLE,
    R_TYPE,
    R_PAY,
    R_CSUM
  } rx_state_t;

  typedef enum logic [2:0] {
    T_IDLE,
    T_SYNC,
    T_TYPE,
    T_PAY,
    T_CSUM
  } tx_state_t;

  function automatic int nbytes(input int w);
    return (w + 7) / 8;
  endfunction

endpackage

// File: rtl/uart_frame_tx.sv
// TX half of the framed link: change detection, round-robin arbitration
// and the frame serialiser.
//
// state  | meaning
// T_IDLE | nothing pending, tx_valid low
// T_SYNC | presenting 0x5A
// T_TYPE | presenting 0x81 (LED) or 0x82 (element)
// T_PAY  | presenting snapshot bytes, LS byte first
// T_CSUM | presenting XOR of TYPE and payload bytes
//
// Ports:
//   clk, rst_n      clock, synchronous active-low reset
//   ena             0 freezes every register
//   led_data        LED state to report
//   element_data    segment/anode state to report
//   tx_data/valid   byte stream to UART TX, held stable until tx_ready
//   tx_ready        UART TX accepts the presented byte
module uart_frame_tx
  import uart_link_pkg::*;
#(
  parameter int LED_COUNT      = 16,
  parameter int ELEMENT_COUNT  = 12,
  parameter int REFRESH_CYCLES = 0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     ena,
  input  logic [LED_COUNT-1:0]     led_data,
  input  logic [ELEMENT_COUNT-1:0] element_data,
  output logic [7:0]               tx_data,
  output logic                     tx_valid,
  input  logic                     tx_ready
);

  localparam int LED_NB  = nbytes(LED_COUNT);
  localparam int ELEM_NB = nbytes(ELEMENT_COUNT);
  localparam int PAY_NB  = (LED_NB > ELEM_NB) ? LED_NB : ELEM_NB;
  localparam int PAY_W   = 8 * PAY_NB;
  localparam logic [2:0] LED_LAST  = 3'(LED_NB - 1);
  localparam logic [2:0] ELEM_LAST = 3'(ELEM_NB - 1);

  tx_state_t                state, state_nxt;
  logic                     led_pend, elem_pend;
  logic                     last_elem;   // type served by the most recent frame
  logic                     cur_elem;    // type of the frame in flight
  logic                     start, pick_elem, any_pend, byte_fire, refresh_tick;
  logic [LED_COUNT-1:0]     led_snap;
  logic [ELEMENT_COUNT-1:0] elem_snap;
  logic [2:0]               idx, last_idx;
  logic [7:0]               csum, pay_byte;
  logic [PAY_W-1:0]         pay_vec;

  generate
    if (REFRESH_CYCLES > 0) begin : g_refresh
      localparam int RW = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
      logic [RW-1:0] refresh_cnt;
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          refresh_cnt <= RW'(REFRESH_CYCLES - 1);
        end else if (ena) begin
          if (refresh_cnt == '0) refresh_cnt <= RW'(REFRESH_CYCLES - 1);
          else                   refresh_cnt <= refresh_cnt - 1'b1;
        end
      end
      assign refresh_tick = ena && (refresh_cnt == '0);
    end else begin : g_no_refresh
      assign refresh_tick = 1'b0;
    end
  endgenerate

  assign any_pend  = led_pend | elem_pend;
  // With both pending, the type that did not go out last wins.
  assign pick_elem = elem_pend && (!led_pend || !last_elem);
  assign byte_fire = tx_valid && tx_ready && ena;
  assign last_idx  = cur_elem ? ELEM_LAST : LED_LAST;
  assign pay_vec   = cur_elem ? PAY_W'(elem_snap) : PAY_W'(led_snap);

  always_comb begin
    pay_byte = 8'h00;
    for (int i = 0; i < PAY_NB; i++) begin
      if (idx == 3'(i)) pay_byte = pay_vec[i*8 +: 8];
    end
  end

  // Output byte is a pure function of registered state, so it cannot move
  // while the handshake is stalled.
  always_comb begin
    tx_data  = 8'h00;
    tx_valid = 1'b1;
    case (state)
      T_SYNC:  tx_data = TX_SYNC;
      T_TYPE:  tx_data = cur_elem ? TX_TYPE_ELEM : TX_TYPE_LED;
      T_PAY:   tx_data = pay_byte;
      T_CSUM:  tx_data = csum;
      default: tx_valid = 1'b0;
    endcase
  end

  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    case (state)
      T_IDLE: begin
        if (any_pend) begin
          start     = 1'b1;
          state_nxt = T_SYNC;
        end
      end
      T_SYNC: if (byte_fire) state_nxt = T_TYPE;
      T_TYPE: if (byte_fire) state_nxt = T_PAY;
      T_PAY:  if (byte_fire && idx == last_idx) state_nxt = T_CSUM;
      T_CSUM: begin
        if (byte_fire) begin
          if (any_pend) begin
            start     = 1'b1;
            state_nxt = T_SYNC;
          end else begin
            state_nxt = T_IDLE;
          end
        end
      end
      default: state_nxt = T_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= T_IDLE;
      led_pend  <= 1'b1;
      elem_pend <= 1'b1;
      last_elem <= 1'b1;
      cur_elem  <= 1'b0;
      led_snap  <= '0;
      elem_snap <= '0;
      idx       <= '0;
      csum      <= '0;
    end else if (ena) begin
      state <= state_nxt;

      if (start) begin
        cur_elem  <= pick_elem;
        last_elem <= pick_elem;
        idx       <= '0;
        csum      <= pick_elem ? TX_TYPE_ELEM : TX_TYPE_LED;
        if (pick_elem) elem_snap <= element_data;
        else           led_snap  <= led_data;
      end else if (state == T_PAY && byte_fire) begin
        idx  <= idx + 1'b1;
        csum <= csum ^ pay_byte;
      end

      // Pending tracks "input differs from what was last framed"; a change
      // during a frame of the same type re-arms it against the snapshot.
      if (start && !pick_elem)                           led_pend <= 1'b0;
      else if (refresh_tick || (led_data != led_snap))   led_pend <= 1'b1;

      if (start && pick_elem)                            elem_pend <= 1'b0;
      else if (refresh_tick || (element_data != elem_snap)) elem_pend <= 1'b1;
    end
  end

endmodule

// File: rtl/uart_frame_link.sv
// Framed, checksummed byte protocol between the UART byte core and board I/O.
// RX parses host frames (A5, TYPE, payload LS-first, XOR checksum) into the
// switch and button registers; TX reports LED and element state on change or
// periodic refresh (see uart_frame_tx).
//
// state  | meaning
// R_IDLE | hunting for 0xA5, other bytes dropped
// R_TYPE | expecting 0x01 (switches) or 0x02 (buttons)
// R_PAY  | collecting payload bytes, LS byte first
// R_CSUM | expecting XOR of TYPE and payload
//
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   ena               0 freezes all state
//   rx_data/valid     received byte; rx_ready = ena
//   tx_data/valid     byte to UART TX; tx_ready accepts it
//   led_data          LED state to report
//   element_data      segment/anode state to report
//   switch_data       host-written switch register
//   button_data       host-written button register
//   frame_err         one-cycle pulse per rejected RX frame
//   err_count         rejected frames, saturating at 255
module uart_frame_link
  import uart_link_pkg::*;
#(
  parameter int SWITCH_COUNT   = 16,
  parameter int BUTTON_COUNT   = 5,
  parameter int LED_COUNT      = 16,
  parameter int ELEMENT_COUNT  = 12,
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int REFRESH_CYCLES = 0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     ena,
  input  logic [7:0]               rx_data,
  input  logic                     rx_valid,
  output logic                     rx_ready,
  output logic [7:0]               tx_data,
  output logic                     tx_valid,
  input  logic                     tx_ready,
  input  logic [LED_COUNT-1:0]     led_data,
  input  logic [ELEMENT_COUNT-1:0] element_data,
  output logic [SWITCH_COUNT-1:0]  switch_data,
  output logic [BUTTON_COUNT-1:0]  button_data,
  output logic                     frame_err,
  output logic [7:0]               err_count
);

  localparam int SW_NB  = nbytes(SWITCH_COUNT);
  localparam int BTN_NB = nbytes(BUTTON_COUNT);
  localparam int RX_NB  = (SW_NB > BTN_NB) ? SW_NB : BTN_NB;
  localparam int RX_W   = 8 * RX_NB;
  localparam int TW     = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [2:0]    SW_LAST  = 3'(SW_NB - 1);
  localparam logic [2:0]    BTN_LAST = 3'(BTN_NB - 1);
  localparam logic [TW-1:0] TMO_LOAD = TW'(TIMEOUT_CYCLES - 1);

  rx_state_t   rx_state, rx_state_nxt;
  logic        rx_fire, is_btn, err_nxt, commit;
  logic [2:0]  byte_idx, last_idx;
  logic [7:0]  csum;
  logic [RX_W-1:0] rx_buf;
  logic [TW-1:0]   tmo_cnt;

  assign rx_ready = ena;
  assign rx_fire  = rx_valid && ena;
  assign last_idx = is_btn ? BTN_LAST : SW_LAST;

  always_comb begin
    rx_state_nxt = rx_state;
    err_nxt      = 1'b0;
    commit       = 1'b0;
    // An arriving byte on the terminal cycle still counts as in time.
    if (rx_state != R_IDLE && !rx_fire && tmo_cnt == '0) begin
      err_nxt      = 1'b1;
      rx_state_nxt = R_IDLE;
    end else if (rx_fire) begin
      case (rx_state)
        R_IDLE: if (rx_data == RX_SYNC) rx_state_nxt = R_TYPE;
        R_TYPE: begin
          if (rx_data == RX_TYPE_SW || rx_data == RX_TYPE_BTN) begin
            rx_state_nxt = R_PAY;
          end else begin
            err_nxt      = 1'b1;
            rx_state_nxt = R_IDLE;
          end
        end
        R_PAY: if (byte_idx == last_idx) rx_state_nxt = R_CSUM;
        R_CSUM: begin
          rx_state_nxt = R_IDLE;
          if (rx_data == csum) commit  = 1'b1;
          else                 err_nxt = 1'b1;
        end
        default: rx_state_nxt = R_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_state    <= R_IDLE;
      is_btn      <= 1'b0;
      byte_idx    <= '0;
      csum        <= '0;
      rx_buf      <= '0;
      tmo_cnt     <= TMO_LOAD;
      switch_data <= '0;
      button_data <= '0;
      err_count   <= '0;
    end else if (ena) begin
      rx_state <= rx_state_nxt;

      if (rx_fire)                          tmo_cnt <= TMO_LOAD;
      else if (rx_state != R_IDLE && tmo_cnt != '0) tmo_cnt <= tmo_cnt - 1'b1;

      if (rx_fire && rx_state == R_TYPE) begin
        is_btn   <= (rx_data == RX_TYPE_BTN);
        byte_idx <= '0;
        csum     <= rx_data;
      end

      if (rx_fire && rx_state == R_PAY) begin
        byte_idx <= byte_idx + 1'b1;
        csum     <= csum ^ rx_data;
        for (int i = 0; i < RX_NB; i++) begin
          if (byte_idx == 3'(i)) rx_buf[i*8 +: 8] <= rx_data;
        end
      end

      // Truncation to the register width drops the unused MS payload bits.
      if (commit) begin
        if (is_btn) button_data <= rx_buf[BUTTON_COUNT-1:0];
        else        switch_data <= rx_buf[SWITCH_COUNT-1:0];
      end

      if (err_nxt && err_count != 8'hFF) err_count <= err_count + 1'b1;
    end
  end

  // Kept outside the ena gate so a pulse never stretches across a freeze.
  always_ff @(posedge clk) begin
    if (!rst_n) frame_err <= 1'b0;
    else        frame_err <= err_nxt && ena;
  end

  uart_frame_tx #(
    .LED_COUNT      (LED_COUNT),
    .ELEMENT_COUNT  (ELEMENT_COUNT),
    .REFRESH_CYCLES (REFRESH_CYCLES)
  ) u_tx (
    .clk          (clk),
    .rst_n        (rst_n),
    .ena          (ena),
    .led_data     (led_data),
    .element_data (element_data),
    .tx_data      (tx_data),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready)
  );

endmodule
